// File: rtl/coolgirl_irq_unit.sv
// coolgirl_irq_unit: shared mapper IRQ engine with MMC3 A12, CPU-cycle and VRC scanline modes
module coolgirl_irq_unit #(
  parameter int COUNTER_WIDTH = 16,
  parameter int A12_FILTER    = 3,
  parameter int PRESCALE_INIT = 341
) (
  input  logic                     m2_i,
  input  logic                     rst_ni,
  input  logic [1:0]               mode_i,
  input  logic [COUNTER_WIDTH-1:0] reload_value_i,
  input  logic                     reload_we_i,
  input  logic                     counter_load_i,
  input  logic                     enable_we_i,
  input  logic                     enable_in_i,
  input  logic                     ack_i,
  input  logic                     ppu_a12_i,
  output logic                     irq_o,
  output logic [COUNTER_WIDTH-1:0] counter_o
);
  localparam int CW = COUNTER_WIDTH;
  typedef enum logic [1:0] {MODE_OFF, MODE_A12, MODE_CPU, MODE_VRC} mode_e;
  mode_e          mode_q;
  logic           a12_s1_q, a12_s2_q;
  logic [2:0]     low_cnt_q, low_cnt_d;
  logic [8:0]     pre_q, pre_d;
  logic [CW-1:0]  counter_q, counter_d, reload_q, reload_d;
  logic           enable_q, enable_d, pending_q, pending_d, rpend_q, rpend_d, irq_q;
  logic           mode_chg, a12_ev, pre_wrap, tick, set, m1_reload;
  logic [7:0]     m1_next;
  always_comb begin
    mode_chg  = mode_i != mode_q;
    a12_ev    = a12_s2_q && low_cnt_q == 3'(A12_FILTER);
    low_cnt_d = a12_s2_q ? 3'd0 : (low_cnt_q == 3'(A12_FILTER) ? low_cnt_q : low_cnt_q + 3'd1);
    pre_wrap  = pre_q < 9'd3;
    // a load or a mode change swallows whatever tick this cycle would have produced
    tick      = !counter_load_i && !mode_chg &&
                (mode_q == MODE_A12 ? a12_ev :
                 mode_q == MODE_CPU ? enable_q :
                 mode_q == MODE_VRC && enable_q && pre_wrap);
    pre_d     = (counter_load_i || mode_chg) ? 9'(PRESCALE_INIT) :
                (mode_q == MODE_VRC && enable_q) ? (pre_wrap ? pre_q + 9'd338 : pre_q - 9'd3) : pre_q;
    m1_reload = counter_q[7:0] == 8'd0 || rpend_q;
    m1_next   = m1_reload ? reload_q[7:0] : counter_q[7:0] - 8'd1;
    counter_d = counter_q;
    rpend_d   = rpend_q;
    set       = 1'b0;
    if (tick && mode_q == MODE_A12) begin
      counter_d = {{(CW-8){1'b0}}, m1_next};
      rpend_d   = 1'b0;
      set       = m1_next == 8'd0 && enable_q;
    end else if (tick) begin
      counter_d = counter_q == '0 ? reload_q : counter_q - CW'(1);
      set       = counter_q == '0 && enable_q;
    end
    if (reload_we_i && mode_q == MODE_A12) rpend_d = 1'b1;
    if (counter_load_i) begin
      counter_d = reload_value_i;
      rpend_d   = 1'b0;
    end
    reload_d  = reload_we_i ? reload_value_i : reload_q;
    enable_d  = enable_we_i ? enable_in_i : enable_q;
    pending_d = (set || (pending_q && !ack_i)) && !(enable_we_i && !enable_in_i) && !mode_chg;
  end
  always_ff @(posedge m2_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q    <= MODE_OFF;
      a12_s1_q  <= 1'b0;
      a12_s2_q  <= 1'b0;
      low_cnt_q <= 3'd0;
      pre_q     <= 9'(PRESCALE_INIT);
      counter_q <= '0;
      reload_q  <= '0;
      enable_q  <= 1'b0;
      pending_q <= 1'b0;
      rpend_q   <= 1'b0;
      irq_q     <= 1'b1;
    end else begin
      mode_q    <= mode_e'(mode_i);
      a12_s1_q  <= ppu_a12_i;
      a12_s2_q  <= a12_s1_q;
      low_cnt_q <= low_cnt_d;
      pre_q     <= pre_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      rpend_q   <= rpend_d;
      irq_q     <= !pending_d;
    end
  end
  assign irq_o     = irq_q;
  assign counter_o = counter_q;
endmodule

// File: tb/tb_coolgirl_irq_unit.sv
// tb_coolgirl_irq_unit: scoreboard bench against a dot-level behavioural model of the IRQ unit
module tb_coolgirl_irq_unit;
  localparam int F = 3;
  logic m2 = 1'b0, rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [15:0] reload_value = '0, counter;
  logic reload_we = 0, counter_load = 0, enable_we = 0, enable_in = 0, ack = 0, ppu_a12 = 0, irq;
  always #5 m2 = ~m2;
  coolgirl_irq_unit dut (
    .m2_i(m2), .rst_ni(rst_n), .mode_i(mode), .reload_value_i(reload_value),
    .reload_we_i(reload_we), .counter_load_i(counter_load), .enable_we_i(enable_we),
    .enable_in_i(enable_in), .ack_i(ack), .ppu_a12_i(ppu_a12), .irq_o(irq), .counter_o(counter)
  );
  typedef struct {int cnt; bit irq; string tag;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  string phase = "reset";
  int m_cnt, m_rld, m_dots, m_mode;
  bit m_en, m_pend, m_rpend;
  bit pipe[$], shist[$];
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    m_cnt = 0; m_rld = 0; m_dots = 0; m_mode = 0;
    m_en = 0; m_pend = 0; m_rpend = 0;
    pipe = '{0, 0};
    shist.delete();
  endtask
  // one m2 edge of the reference: a line is 341 PPU dots, each CPU cycle covers 3 of them
  task automatic model_step();
    bit s, ev, chg, wrap, raw, tick, set;
    int n;
    s = pipe[0];
    ev = 0;
    if (s && shist.size() >= F) begin
      ev = 1;
      for (int i = 1; i <= F; i++) if (shist[shist.size()-i]) ev = 0;
    end
    shist.push_back(s);
    if (shist.size() > 8) void'(shist.pop_front());
    void'(pipe.pop_front());
    pipe.push_back(ppu_a12);
    chg  = int'(mode) != m_mode;
    wrap = m_dots + 3 > 341;
    raw  = m_mode == 1 ? ev : m_mode == 2 ? m_en : m_mode == 3 ? (m_en && wrap) : 0;
    tick = raw && !counter_load && !chg;
    if (m_mode == 3 && m_en) m_dots = wrap ? m_dots + 3 - 341 : m_dots + 3;
    set = 0;
    if (tick && m_mode == 1) begin
      n = (m_cnt % 256 == 0 || m_rpend) ? m_rld % 256 : m_cnt % 256 - 1;
      m_cnt = n; m_rpend = 0; set = n == 0 && m_en;
    end else if (tick) begin
      set = m_cnt == 0 && m_en;
      m_cnt = m_cnt == 0 ? m_rld : m_cnt - 1;
    end
    if (reload_we) begin m_rld = int'(reload_value); if (m_mode == 1) m_rpend = 1; end
    if (counter_load) begin m_cnt = int'(reload_value); m_dots = 0; m_rpend = 0; end
    if (ack) m_pend = 0;
    if (set) m_pend = 1;
    if (enable_we && !enable_in) m_pend = 0;
    if (chg) begin m_pend = 0; m_dots = 0; m_mode = int'(mode); end
    if (enable_we) m_en = enable_in;
    sb.push_back('{m_cnt, !m_pend, phase});
  endtask
  task automatic step();
    model_step();
    @(negedge m2);
    reload_we = 0; counter_load = 0; enable_we = 0; ack = 0;
  endtask
  task automatic a12_pulse(int lo, int hi);
    ppu_a12 = 0; repeat (lo) step();
    ppu_a12 = 1; repeat (hi) step();
  endtask
  initial forever begin
    @(posedge m2); #2;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, " counter"}, int'(counter), e.cnt);
      chk({e.tag, " irq"}, int'(irq), int'(e.irq));
    end
  end
  initial begin
    int n, e;
    int lows[$];
    repeat (2) @(negedge m2);
    chk("reset counter", int'(counter), 0);
    chk("reset irq", int'(irq), 1);
    rst_n = 1; model_reset();
    phase = "m1";
    mode = 1; step();
    reload_value = 2; reload_we = 1; enable_we = 1; enable_in = 1; step();
    repeat (3) a12_pulse(4, 2);
    repeat (4) step();
    chk("m1 count to zero", int'(counter), 0);
    chk("m1 irq on third event", int'(irq), 0);
    phase = "filter";
    ack = 1; step();
    a12_pulse(4, 2); repeat (4) step();
    chk("filter reload", int'(counter), 2);
    a12_pulse(2, 2); repeat (4) step();
    chk("filter reject", int'(counter), 2);
    a12_pulse(3, 2); repeat (4) step();
    chk("filter accept", int'(counter), 1);
    phase = "m2";
    ppu_a12 = 0; mode = 2; step();
    reload_value = 5; reload_we = 1; counter_load = 1; enable_we = 1; enable_in = 1; step();
    n = 0;
    while (irq && n < 20) begin step(); n++; end
    chk("m2 irq latency", n, 6);
    chk("m2 reload", int'(counter), 5);
    step(); ack = 1; step();
    chk("m2 ack", int'(irq), 1);
    n = 0;
    while (counter != 0 && n < 20) begin step(); n++; end
    ack = 1; step();
    chk("m2 ack vs set", int'(irq), 0);
    phase = "en_clr";
    enable_we = 1; enable_in = 0; step();
    chk("enable clear irq", int'(irq), 1);
    phase = "rst";
    enable_we = 1; enable_in = 1; reload_value = 100; counter_load = 1; step();
    repeat (5) step();
    #2 rst_n = 0;
    #1 chk("async rst counter", int'(counter), 0);
    chk("async rst irq", int'(irq), 1);
    model_reset();
    @(negedge m2); rst_n = 1;
    phase = "switch";
    ppu_a12 = 0;
    enable_we = 1; enable_in = 1; reload_value = 3; reload_we = 1; counter_load = 1; step();
    n = 0;
    while (irq && n < 20) begin step(); n++; end
    chk("switch pending", int'(irq), 0);
    step();
    mode = 1; step();
    chk("switch irq", int'(irq), 1);
    chk("switch hold", int'(counter), 2);
    repeat (4) step();
    chk("switch hold idle", int'(counter), 2);
    a12_pulse(4, 2); repeat (3) step();
    chk("switch a12 event", int'(counter), 1);
    phase = "m3";
    mode = 3; step();
    reload_value = 0; reload_we = 1; counter_load = 1; enable_we = 1; enable_in = 1; step();
    e = 0;
    while (lows.size() < 4 && e < 600) begin
      ack = 1; step(); e++;
      if (!irq) lows.push_back(e);
    end
    chk("m3 tick count", lows.size(), 4);
    if (lows.size() == 4) begin
      chk("m3 first tick", lows[0], 114);
      chk("m3 gap 1", lows[1] - lows[0], 114);
      chk("m3 gap 2", lows[2] - lows[1], 114);
      chk("m3 gap 3", lows[3] - lows[2], 113);
    end
    phase = "rand";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 127) == 0) mode = 2'($urandom_range(0, 3));
      reload_we    = $urandom_range(0, 7) == 0;
      reload_value = 16'($urandom_range(0, 6));
      counter_load = $urandom_range(0, 63) == 0;
      enable_we    = $urandom_range(0, 11) == 0;
      enable_in    = $urandom_range(0, 3) != 0;
      ack          = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 2) == 0) ppu_a12 = ~ppu_a12;
      step();
    end
    repeat (2) @(negedge m2);
    chk("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
